// File: rtl/qr_sram_arbiter.sv
// Shares one 32-bit SRAM word (four 256x8 banks) between the input-stream writer
// and two read requesters. Writes always win; reads are round-robin with optional locked bursts.
module qr_sram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_vld,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [1:0]    i_rq_vld,
    input  logic [AW-1:0] i_rq_addr0,
    input  logic [AW-1:0] i_rq_addr1,
    input  logic [1:0]    i_rq_last,
    output logic [1:0]    o_rq_rdy,
    output logic          o_rd_vld,
    output logic          o_rd_id,
    output logic [DW-1:0] o_rd_data,
    output logic          o_sram_cen,
    output logic          o_sram_wen,
    output logic [AW-1:0] o_sram_a,
    output logic [DW-1:0] o_sram_d,
    input  logic [DW-1:0] i_sram_q
);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        BURST0 = 2'd1,
        BURST1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   rr_ptr_q, rr_ptr_d;
    logic   rd_vld_q, rd_vld_d;
    logic   rd_id_q, rd_id_d;

    logic   gnt_vld;
    logic   gnt_id;
    logic   gnt_last;

    // Read grant: suppressed by a write beat and held off entirely during reset.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (!i_rst && !i_wr_vld) begin
            unique case (state_q)
                ARB: begin
                    if (i_rq_vld[rr_ptr_q]) begin
                        gnt_vld = 1'b1;
                        gnt_id  = rr_ptr_q;
                    end else if (i_rq_vld[~rr_ptr_q]) begin
                        gnt_vld = 1'b1;
                        gnt_id  = ~rr_ptr_q;
                    end
                end
                BURST0: begin
                    if (i_rq_vld[0]) begin
                        gnt_vld = 1'b1;
                        gnt_id  = 1'b0;
                    end
                end
                BURST1: begin
                    if (i_rq_vld[1]) begin
                        gnt_vld = 1'b1;
                        gnt_id  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        gnt_last = i_rq_last[gnt_id];
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q != ARB && state_q != BURST0 && state_q != BURST1) begin
            state_d = ARB;
        end else if (gnt_vld) begin
            if (state_q == ARB) begin
                rr_ptr_d = ~gnt_id;
                if (!gnt_last) begin
                    state_d = gnt_id ? BURST1 : BURST0;
                end
            end else if (gnt_last) begin
                // Burst owner finished: the other requester goes first next time.
                state_d  = ARB;
                rr_ptr_d = ~gnt_id;
            end
        end
        rd_vld_d = gnt_vld;
        rd_id_d  = gnt_vld ? gnt_id : rd_id_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ARB;
            rr_ptr_q <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_id_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            rd_vld_q <= rd_vld_d;
            rd_id_q  <= rd_id_d;
        end
    end

    always_comb begin
        o_rq_rdy   = 2'b00;
        o_sram_cen = 1'b1;
        o_sram_wen = 1'b1;
        o_sram_a   = '0;
        if (!i_rst && i_wr_vld) begin
            o_sram_cen = 1'b0;
            o_sram_wen = 1'b0;
            o_sram_a   = i_wr_addr;
        end else if (gnt_vld) begin
            o_sram_cen       = 1'b0;
            o_sram_a         = gnt_id ? i_rq_addr1 : i_rq_addr0;
            o_rq_rdy[gnt_id] = 1'b1;
        end
    end

    assign o_sram_d  = i_wr_data;
    assign o_rd_data = i_sram_q;
    assign o_rd_vld  = rd_vld_q;
    assign o_rd_id   = rd_id_q;

endmodule

// File: tb/tb_qr_sram_arbiter.sv
// Directed bench for qr_sram_arbiter with a behavioural SRAM and a read-return scoreboard.
module tb_qr_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_vld;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rq_vld;
    logic [7:0]  rq_addr0;
    logic [7:0]  rq_addr1;
    logic [1:0]  rq_last;
    logic [1:0]  rq_rdy;
    logic        rd_vld;
    logic        rd_id;
    logic [31:0] rd_data;
    logic        sram_cen;
    logic        sram_wen;
    logic [7:0]  sram_a;
    logic [31:0] sram_d;
    logic [31:0] sram_q;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int   n_checks = 0;
    int   n_errors = 0;
    logic pend = 1'b0;

    always #5 clk = ~clk;

    qr_sram_arbiter #(.AW(8), .DW(32)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_vld   (wr_vld),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_rq_vld   (rq_vld),
        .i_rq_addr0 (rq_addr0),
        .i_rq_addr1 (rq_addr1),
        .i_rq_last  (rq_last),
        .o_rq_rdy   (rq_rdy),
        .o_rd_vld   (rd_vld),
        .o_rd_id    (rd_id),
        .o_rd_data  (rd_data),
        .o_sram_cen (sram_cen),
        .o_sram_wen (sram_wen),
        .o_sram_a   (sram_a),
        .o_sram_d   (sram_d),
        .i_sram_q   (sram_q)
    );

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_a] <= sram_d;
            else           sram_q <= mem[sram_a];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check last cycle's return, drive new inputs, check the combinational grant.
    task automatic cycle(input logic wv, input logic [7:0] wa, input logic [31:0] wd,
                         input logic [1:0] rv, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [1:0] last, input logic [1:0] exp_rdy);
        exp_t        e;
        logic [7:0]  exp_a;
        @(negedge clk);
        chk("rd_vld", {63'd0, rd_vld}, {63'd0, pend});
        if (pend && sb.size() > 0) begin
            e = sb.pop_front();
            chk("rd_id", {63'd0, rd_id}, {63'd0, e.id});
            chk("rd_data", {32'd0, rd_data}, {32'd0, e.data});
        end
        wr_vld = wv; wr_addr = wa; wr_data = wd;
        rq_vld = rv; rq_addr0 = a0; rq_addr1 = a1; rq_last = last;
        #1;
        exp_a = wv ? wa : exp_rdy[0] ? a0 : exp_rdy[1] ? a1 : 8'd0;
        chk("rq_rdy", {62'd0, rq_rdy}, {62'd0, exp_rdy});
        chk("sram_cen", {63'd0, sram_cen}, {63'd0, !(wv || (exp_rdy != 2'b00))});
        chk("sram_wen", {63'd0, sram_wen}, {63'd0, !wv});
        chk("sram_a", {56'd0, sram_a}, {56'd0, exp_a});
        chk("sram_d", {32'd0, sram_d}, {32'd0, wd});
        if (exp_rdy[0]) sb.push_back('{id: 1'b0, data: ref_mem[a0]});
        if (exp_rdy[1]) sb.push_back('{id: 1'b1, data: ref_mem[a1]});
        pend = (exp_rdy != 2'b00);
        if (wv) ref_mem[wa] = wd;
    endtask

    task automatic idle();
        cycle(1'b0, 8'd0, 32'd0, 2'b00, 8'd0, 8'd0, 2'b11, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        wr_vld = 1'b1; wr_addr = 8'd7; wr_data = 32'hdead; rq_vld = 2'b11;
        rq_addr0 = 8'd1; rq_addr1 = 8'd2; rq_last = 2'b11;
        #2;
        chk("rst_rdy", {62'd0, rq_rdy}, 64'd0);
        chk("rst_cen", {63'd0, sram_cen}, 64'd1);
        chk("rst_rd_vld", {63'd0, rd_vld}, 64'd0);
        chk("rst_rd_id", {63'd0, rd_id}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_cen_hold", {63'd0, sram_cen}, 64'd1);
        chk("rst_rd_vld_hold", {63'd0, rd_vld}, 64'd0);
        wr_vld = 1'b0; rq_vld = 2'b00;
        rst = 1'b0;

        // Stream fill, then a single read from each requester.
        for (int i = 0; i < 200; i++) cycle(1'b1, 8'(i), 32'(i * 3), 2'b00, 8'd0, 8'd0, 2'b11, 2'b00);
        cycle(1'b0, 8'd0, 32'd0, 2'b01, 8'd10, 8'd0, 2'b11, 2'b01);
        cycle(1'b0, 8'd0, 32'd0, 2'b10, 8'd0, 8'd11, 2'b11, 2'b10);

        // Round robin on single beats.
        for (int k = 0; k < 6; k++)
            cycle(1'b0, 8'd0, 32'd0, 2'b11, 8'd20, 8'd21, 2'b11, (k % 2 == 0) ? 2'b01 : 2'b10);

        // req0 burst of four with req1 waiting.
        for (int k = 0; k < 4; k++)
            cycle(1'b0, 8'd0, 32'd0, 2'b11, 8'(30 + k), 8'd40, {1'b1, (k == 3)}, 2'b01);
        cycle(1'b0, 8'd0, 32'd0, 2'b11, 8'd34, 8'd40, 2'b11, 2'b10);

        // req1 burst interrupted by a write; req0 stays locked out.
        cycle(1'b0, 8'd0, 32'd0, 2'b10, 8'd0, 8'd50, 2'b01, 2'b10);
        cycle(1'b1, 8'd100, 32'hab, 2'b11, 8'd0, 8'd51, 2'b01, 2'b00);
        cycle(1'b0, 8'd0, 32'd0, 2'b11, 8'd0, 8'd51, 2'b01, 2'b10);
        cycle(1'b0, 8'd0, 32'd0, 2'b11, 8'd0, 8'd52, 2'b11, 2'b10);
        cycle(1'b0, 8'd0, 32'd0, 2'b11, 8'd70, 8'd53, 2'b11, 2'b01);

        // Same-address write/read collision.
        cycle(1'b1, 8'd5, 32'h11, 2'b00, 8'd0, 8'd0, 2'b11, 2'b00);
        cycle(1'b1, 8'd5, 32'h22, 2'b01, 8'd5, 8'd0, 2'b11, 2'b00);
        cycle(1'b0, 8'd0, 32'd0, 2'b01, 8'd5, 8'd0, 2'b11, 2'b01);
        cycle(1'b0, 8'd0, 32'd0, 2'b10, 8'd0, 8'd100, 2'b11, 2'b10);

        // Reset with a read in flight inside a req0 burst.
        cycle(1'b0, 8'd0, 32'd0, 2'b01, 8'd60, 8'd0, 2'b10, 2'b01);
        #1;
        rst = 1'b1;
        rq_vld = 2'b00;
        sb.delete();
        pend = 1'b0;
        #1;
        chk("midrst_rdy", {62'd0, rq_rdy}, 64'd0);
        chk("midrst_cen", {63'd0, sram_cen}, 64'd1);
        chk("midrst_rd_vld_async", {63'd0, rd_vld}, 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_rd_vld_edge", {63'd0, rd_vld}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 8'd0, 32'd0, 2'b11, 8'd61, 8'd62, 2'b11, 2'b01);
        cycle(1'b0, 8'd0, 32'd0, 2'b11, 8'd61, 8'd62, 2'b11, 2'b10);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
